// File: rtl/pipe_control_unit_if.sv
// Bus between the ID-stage driver and the pipelined control unit: instruction in,
// per-slot enable/flush, decoded and registered control bundles out.
interface pipe_control_unit_if #(
    parameter int STAGES = 3,
    parameter int CW     = 24
);
    logic [31:0]        instr;
    logic               instr_valid;
    logic [STAGES-1:0]  en;
    logic [STAGES-1:0]  flush;
    logic [CW-1:0]      dec_ctrl;
    logic [STAGES*CW-1:0] stage_ctrl;
    logic               hazard;
    logic               iREN;
    logic               halted;

    modport master (
        output instr, instr_valid, en, flush,
        input  dec_ctrl, stage_ctrl, hazard, iREN, halted
    );

    modport slave (
        input  instr, instr_valid, en, flush,
        output dec_ctrl, stage_ctrl, hazard, iREN, halted
    );
endinterface

// File: rtl/pipe_control_unit.sv
// MIPS control decode plus STAGES registered control slots with per-slot enable/flush,
// load-use hazard detection against slot 0 and a sticky halt that gates fetch.
module pipe_control_unit #(
    parameter int STAGES = 3,
    parameter int CW     = 24
) (
    input logic                CLK,
    input logic                nRST,
    pipe_control_unit_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE   = 6'h05, OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI  = 6'h0a, OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c, OP_ORI   = 6'h0d, OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f, OP_LW    = 6'h23, OP_SW    = 6'h2b;
    localparam logic [5:0] OP_HALT  = 6'h3f;

    localparam logic [5:0] FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23, FN_AND  = 6'h24, FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    localparam logic [3:0] ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2, ALU_SUB  = 4'd3;
    localparam logic [3:0] ALU_AND = 4'd4, ALU_OR  = 4'd5, ALU_XOR = 4'd6, ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_SLT = 4'd8, ALU_SLTU = 4'd9;

    localparam int B_VALID = 0, B_DREN = 2, B_HALT = 5;

    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    assign op = bus.instr[31:26];
    assign rs = bus.instr[25:21];
    assign rt = bus.instr[20:16];
    assign rd = bus.instr[15:11];
    assign fn = bus.instr[5:0];

    logic       regwr, dren, dwen, alusrc, hlt, bne;
    logic [1:0] extop, memtoreg, pcsrc;
    logic [3:0] aluop;
    logic [4:0] wsel;

    always_comb begin
        regwr = 1'b0; dren = 1'b0; dwen = 1'b0; alusrc = 1'b0; hlt = 1'b0; bne = 1'b0;
        extop = 2'b00; memtoreg = 2'b00; pcsrc = 2'b00; aluop = ALU_SLL; wsel = 5'd0;
        case (op)
            OP_RTYPE: begin
                wsel  = rd;
                regwr = 1'b1;
                case (fn)
                    FN_SLLV:         aluop = ALU_SLL;
                    FN_SRLV:         aluop = ALU_SRL;
                    FN_ADD, FN_ADDU: aluop = ALU_ADD;
                    FN_SUB, FN_SUBU: aluop = ALU_SUB;
                    FN_AND:          aluop = ALU_AND;
                    FN_OR:           aluop = ALU_OR;
                    FN_XOR:          aluop = ALU_XOR;
                    FN_NOR:          aluop = ALU_NOR;
                    FN_SLT:          aluop = ALU_SLT;
                    FN_SLTU:         aluop = ALU_SLTU;
                    FN_JR: begin
                        pcsrc = 2'b11;
                        regwr = 1'b0;
                    end
                    default: begin
                        regwr = 1'b0;
                        wsel  = 5'd0;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                alusrc = 1'b1;
                regwr  = 1'b1;
                wsel   = rt;
                case (op)
                    OP_ADDI, OP_ADDIU: begin aluop = ALU_ADD;  extop = 2'b01; end
                    OP_SLTI:           begin aluop = ALU_SLT;  extop = 2'b01; end
                    OP_SLTIU:          begin aluop = ALU_SLTU; extop = 2'b01; end
                    OP_ANDI:           aluop = ALU_AND;
                    OP_ORI:            aluop = ALU_OR;
                    default:           aluop = ALU_XOR;
                endcase
            end
            OP_LUI: begin
                extop = 2'b10; alusrc = 1'b1; regwr = 1'b1; wsel = rt;
            end
            OP_LW: begin
                dren = 1'b1; memtoreg = 2'b01; aluop = ALU_ADD; alusrc = 1'b1;
                extop = 2'b01; regwr = 1'b1; wsel = rt;
            end
            OP_SW: begin
                dwen = 1'b1; aluop = ALU_ADD; alusrc = 1'b1; extop = 2'b01;
            end
            OP_BEQ, OP_BNE: begin
                pcsrc = 2'b01; aluop = ALU_SUB; extop = 2'b01; bne = (op == OP_BNE);
            end
            OP_J:    pcsrc = 2'b10;
            OP_JAL: begin
                pcsrc = 2'b10; regwr = 1'b1; wsel = 5'd31; memtoreg = 2'b10;
            end
            OP_HALT: hlt = 1'b1;
            default: ;
        endcase
    end

    logic [CW-1:0] dec;
    always_comb begin
        dec = '0;
        if (bus.instr_valid) begin
            dec[0]     = 1'b1;
            dec[1]     = regwr && (wsel != 5'd0);
            dec[2]     = dren;
            dec[3]     = dwen;
            dec[4]     = alusrc;
            dec[5]     = hlt;
            dec[7:6]   = extop;
            dec[9:8]   = memtoreg;
            dec[11:10] = pcsrc;
            dec[12]    = bne;
            dec[16:13] = aluop;
            dec[21:17] = wsel;
        end
    end
    assign bus.dec_ctrl = dec;

    logic [CW-1:0] slot_q [STAGES];
    logic [CW-1:0] src    [STAGES];
    logic          reads_rs, reads_rt, hazard;

    assign reads_rs = !(op == OP_J || op == OP_JAL || op == OP_LUI || op == OP_HALT);
    assign reads_rt = (op == OP_RTYPE || op == OP_BEQ || op == OP_BNE || op == OP_SW);

    always_comb begin
        hazard = 1'b0;
        if (bus.instr_valid && slot_q[0][B_VALID] && slot_q[0][B_DREN]
            && slot_q[0][21:17] != 5'd0) begin
            hazard = (reads_rs && rs == slot_q[0][21:17])
                  || (reads_rt && rt == slot_q[0][21:17]);
        end
    end
    assign bus.hazard = hazard;

    // A stalled ID instruction enters slot 0 as a bubble while the load completes.
    always_comb begin
        src[0] = hazard ? '0 : dec;
        for (int k = 1; k < STAGES; k++) src[k] = slot_q[k-1];
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int k = 0; k < STAGES; k++) slot_q[k] <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (bus.flush[k])   slot_q[k] <= '0;
                else if (bus.en[k]) slot_q[k] <= src[k];
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_out
        assign bus.stage_ctrl[k*CW +: CW] = slot_q[k];
    end

    logic halt_any, halted_q;
    always_comb begin
        halt_any = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            halt_any = halt_any | (slot_q[k][B_VALID] & slot_q[k][B_HALT]);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) halted_q <= 1'b0;
        else if (slot_q[STAGES-1][B_VALID] && slot_q[STAGES-1][B_HALT]) halted_q <= 1'b1;
    end

    assign bus.halted = halted_q;
    assign bus.iREN   = !(halted_q || halt_any || dec[B_HALT]);
endmodule

// File: tb/tb_pipe_control_unit.sv
// Randomized and directed checks of pipe_control_unit (STAGES=3 and STAGES=5) against a
// field-level behavioural model of decode, slot movement, hazard and halt.
module tb_pipe_control_unit;
    localparam int CW = 24;
    localparam int SA = 3;
    localparam int SB = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE   = 6'h05, OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_SLTI  = 6'h0a, OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c, OP_ORI   = 6'h0d, OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f, OP_LW    = 6'h23, OP_SW    = 6'h2b;
    localparam logic [5:0] OP_HALT  = 6'h3f;
    localparam logic [5:0] FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20, FN_ADDU = 6'h21, FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23, FN_AND  = 6'h24, FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    logic CLK = 1'b0;
    logic nRST;
    logic [31:0] instr;
    logic iv;
    logic [SA-1:0] en_a, fl_a;
    logic [SB-1:0] en_b, fl_b;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    pipe_control_unit_if #(.STAGES(SA), .CW(CW)) bus_a ();
    pipe_control_unit_if #(.STAGES(SB), .CW(CW)) bus_b ();

    assign bus_a.instr = instr;  assign bus_a.instr_valid = iv;
    assign bus_a.en    = en_a;   assign bus_a.flush       = fl_a;
    assign bus_b.instr = instr;  assign bus_b.instr_valid = iv;
    assign bus_b.en    = en_b;   assign bus_b.flush       = fl_b;

    pipe_control_unit #(.STAGES(SA), .CW(CW)) dut_a (.CLK(CLK), .nRST(nRST), .bus(bus_a.slave));
    pipe_control_unit #(.STAGES(SB), .CW(CW)) dut_b (.CLK(CLK), .nRST(nRST), .bus(bus_b.slave));

    logic [CW-1:0] ms [2][6];
    logic          mh [2];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int nst(input int i);
        return (i == 0) ? SA : SB;
    endfunction

    function automatic logic [CW-1:0] ref_decode(input logic [31:0] w, input logic v);
        logic [5:0] op, fn;
        logic [4:0] rt, rd, ws;
        logic rw, rde, wre, asrc, hl, bn, known;
        logic [1:0] ext, m2r, pcs;
        logic [3:0] aop;
        logic [CW-1:0] b;
        op = w[31:26]; rt = w[20:16]; rd = w[15:11]; fn = w[5:0];
        rw = 0; rde = 0; wre = 0; asrc = 0; hl = 0; bn = 0; known = 1;
        ext = 0; m2r = 0; pcs = 0; aop = 0; ws = 0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_SLLV: aop = 0;  FN_SRLV: aop = 1;
                    FN_ADD, FN_ADDU: aop = 2;  FN_SUB, FN_SUBU: aop = 3;
                    FN_AND: aop = 4;  FN_OR: aop = 5;  FN_XOR: aop = 6;  FN_NOR: aop = 7;
                    FN_SLT: aop = 8;  FN_SLTU: aop = 9;
                    FN_JR: pcs = 2'b11;
                    default: known = 0;
                endcase
                if (known) begin ws = rd; rw = (fn != FN_JR); end
            end
            OP_ADDI, OP_ADDIU: begin aop = 2; ext = 1; asrc = 1; rw = 1; ws = rt; end
            OP_SLTI:  begin aop = 8; ext = 1; asrc = 1; rw = 1; ws = rt; end
            OP_SLTIU: begin aop = 9; ext = 1; asrc = 1; rw = 1; ws = rt; end
            OP_ANDI:  begin aop = 4; asrc = 1; rw = 1; ws = rt; end
            OP_ORI:   begin aop = 5; asrc = 1; rw = 1; ws = rt; end
            OP_XORI:  begin aop = 6; asrc = 1; rw = 1; ws = rt; end
            OP_LUI:   begin ext = 2; asrc = 1; rw = 1; ws = rt; end
            OP_LW:    begin rde = 1; m2r = 1; aop = 2; asrc = 1; ext = 1; rw = 1; ws = rt; end
            OP_SW:    begin wre = 1; aop = 2; asrc = 1; ext = 1; end
            OP_BEQ, OP_BNE: begin pcs = 1; aop = 3; ext = 1; bn = (op == OP_BNE); end
            OP_J:     pcs = 2;
            OP_JAL:   begin pcs = 2; rw = 1; ws = 31; m2r = 2; end
            OP_HALT:  hl = 1;
            default: ;
        endcase
        b = '0;
        if (!v) return b;
        b[0] = 1; b[1] = rw && (ws != 0); b[2] = rde; b[3] = wre; b[4] = asrc; b[5] = hl;
        b[7:6] = ext; b[9:8] = m2r; b[11:10] = pcs; b[12] = bn; b[16:13] = aop; b[21:17] = ws;
        return b;
    endfunction

    function automatic logic ref_hazard(input int i);
        logic [5:0] op;
        logic [4:0] w;
        logic rrs, rrt;
        op  = instr[31:26];
        w   = ms[i][0][21:17];
        rrs = !(op == OP_J || op == OP_JAL || op == OP_LUI || op == OP_HALT);
        rrt = (op == OP_RTYPE || op == OP_BEQ || op == OP_BNE || op == OP_SW);
        if (!(iv && ms[i][0][0] && ms[i][0][2] && w != 0)) return 1'b0;
        return (rrs && instr[25:21] == w) || (rrt && instr[20:16] == w);
    endfunction

    function automatic logic ref_iren(input int i);
        logic h;
        h = mh[i] | ref_decode(instr, iv)[5];
        for (int k = 0; k < nst(i); k++) h = h | (ms[i][k][0] & ms[i][k][5]);
        return !h;
    endfunction

    task automatic settle_check();
        logic [127:0] exp_sc;
        #1;
        if (!nRST) begin
            for (int i = 0; i < 2; i++) begin
                mh[i] = 0;
                for (int k = 0; k < 6; k++) ms[i][k] = '0;
            end
        end
        for (int i = 0; i < 2; i++) begin
            exp_sc = '0;
            for (int k = 0; k < nst(i); k++) exp_sc[k*CW +: CW] = ms[i][k];
            check($sformatf("dec_ctrl[%0d]", i),
                  (i == 0) ? bus_a.dec_ctrl : bus_b.dec_ctrl, ref_decode(instr, iv));
            check($sformatf("stage_ctrl[%0d]", i),
                  (i == 0) ? 128'(bus_a.stage_ctrl) : 128'(bus_b.stage_ctrl), exp_sc);
            check($sformatf("hazard[%0d]", i),
                  (i == 0) ? bus_a.hazard : bus_b.hazard, ref_hazard(i));
            check($sformatf("iREN[%0d]", i), (i == 0) ? bus_a.iREN : bus_b.iREN, ref_iren(i));
            check($sformatf("halted[%0d]", i), (i == 0) ? bus_a.halted : bus_b.halted, mh[i]);
        end
    endtask

    task automatic tick();
        logic [CW-1:0] nx [2][6];
        logic nh [2];
        logic [7:0] e, f;
        logic [CW-1:0] s;
        for (int i = 0; i < 2; i++) begin
            e = (i == 0) ? 8'(en_a) : 8'(en_b);
            f = (i == 0) ? 8'(fl_a) : 8'(fl_b);
            for (int k = 0; k < nst(i); k++) begin
                if (k == 0) s = ref_hazard(i) ? '0 : ref_decode(instr, iv);
                else        s = ms[i][k-1];
                if (f[k])      nx[i][k] = '0;
                else if (e[k]) nx[i][k] = s;
                else           nx[i][k] = ms[i][k];
            end
            nh[i] = mh[i] | (ms[i][nst(i)-1][0] & ms[i][nst(i)-1][5]);
        end
        @(posedge CLK);
        if (nRST) begin
            for (int i = 0; i < 2; i++) begin
                mh[i] = nh[i];
                for (int k = 0; k < nst(i); k++) ms[i][k] = nx[i][k];
            end
        end
        @(negedge CLK);
    endtask

    task automatic step();
        settle_check();
        tick();
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [15] = '{OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE,
                                 OP_ADDI, OP_SLTIU, OP_ANDI, OP_XORI, OP_LUI, OP_LW, OP_LW, OP_SW};
        logic [5:0] fns [14] = '{FN_SLLV, FN_SRLV, FN_JR, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                                 FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU, 6'h3c};
        logic [31:0] w;
        int sel;
        w = $urandom;
        w[25:21] = 5'($urandom_range(7));
        w[20:16] = 5'($urandom_range(7));
        w[15:11] = 5'($urandom_range(7));
        sel = $urandom_range(49);
        if (sel == 49)      w[31:26] = OP_HALT;
        else if (sel >= 46) w[31:26] = 6'($urandom);
        else                w[31:26] = ops[sel % 15];
        if (w[31:26] == OP_RTYPE) w[5:0] = fns[$urandom_range(13)];
        return w;
    endfunction

    initial begin
        nRST = 0; iv = 1; instr = itype(OP_LW, 5'd1, 5'd4, 16'd0);
        en_a = '1; en_b = '1; fl_a = '0; fl_b = '0;
        @(negedge CLK);
        check("rst_stage_a", 128'(bus_a.stage_ctrl), 128'd0);
        check("rst_iren_a", bus_a.iREN, 1'b1);
        check("rst_hazard_a", bus_a.hazard, 1'b0);
        step();
        nRST = 1;
        step();
        check("lw_dren", bus_a.stage_ctrl[2], 1'b1);
        check("lw_memtoreg", bus_a.stage_ctrl[9:8], 2'b01);
        check("lw_wsel", bus_a.stage_ctrl[21:17], 5'd4);

        instr = itype(OP_SW, 5'd2, 5'd4, 16'd8);
        #1 check("hz_sw_rt", bus_a.hazard, 1'b1);
        step();
        check("hz_bubble", bus_a.stage_ctrl[CW-1:0], 24'd0);
        instr = itype(OP_LW, 5'd1, 5'd4, 16'd0);
        step();
        instr = itype(OP_LUI, 5'd4, 5'd4, 16'h1234);
        #1 check("hz_lui", bus_a.hazard, 1'b0);
        step();

        instr = itype(OP_ADDI, 5'd1, 5'd2, 16'd5);
        step();
        instr = rtype(5'd2, 5'd2, 5'd3, FN_ADD);
        step();
        check("add_aluop", bus_a.stage_ctrl[16:13], 4'd2);
        check("add_alusrc", bus_a.stage_ctrl[4], 1'b0);
        check("add_wsel", bus_a.stage_ctrl[21:17], 5'd3);
        check("addi_s1_wsel", bus_a.stage_ctrl[CW+17 +: 5], 5'd2);
        step();
        check("add_s1_wsel", bus_a.stage_ctrl[CW+17 +: 5], 5'd3);
        check("addi_s2_wsel", bus_a.stage_ctrl[2*CW+17 +: 5], 5'd2);

        instr = itype(OP_SW, 5'd5, 5'd6, 16'd0);
        step();
        fl_a = 3'b010;
        step();
        check("flush_wins", bus_a.stage_ctrl[CW +: CW], 24'd0);
        fl_a = '0;
        step();
        en_a = 3'b101; instr = rtype(5'd1, 5'd2, 5'd7, FN_OR);
        step();
        step();
        check("stall_hold", bus_a.stage_ctrl[CW +: CW], ref_decode(itype(OP_SW, 5'd5, 5'd6, 16'd0), 1'b1));
        en_a = '1;

        instr = {OP_HALT, 26'd0};
        #1 check("halt_iren_a", bus_a.iREN, 1'b0);
        step();
        iv = 0; fl_a = '1; fl_b = '1;
        step();
        fl_a = '0; fl_b = '0;
        #1 check("halt_flushed_iren", bus_a.iREN, 1'b1);

        iv = 1; instr = {OP_HALT, 26'd0};
        for (int j = 1; j <= SB + 1; j++) begin
            step();
            iv = 0;
            if (j == SA)     check("halted_a_early", bus_a.halted, 1'b0);
            if (j == SA + 1) check("halted_a", bus_a.halted, 1'b1);
            if (j == SB)     check("halted_b_early", bus_b.halted, 1'b0);
            if (j == SB + 1) check("halted_b", bus_b.halted, 1'b1);
        end
        nRST = 0;
        #1 check("rst_halted", bus_a.halted, 1'b0);
        check("rst_iren", bus_a.iREN, 1'b1);
        step();
        nRST = 1;

        iv = 1; instr = {OP_JAL, 26'h0000123};
        step();
        iv = 0;
        for (int j = 0; j < SB - 1; j++) step();
        check("jal_wsel", bus_b.stage_ctrl[4*CW+17 +: 5], 5'd31);
        check("jal_memtoreg", bus_b.stage_ctrl[4*CW+8 +: 2], 2'b10);
        check("jal_pcsrc", bus_b.stage_ctrl[4*CW+10 +: 2], 2'b10);
        iv = 1; instr = rtype(5'd1, 5'd2, 5'd0, FN_ADD);
        #1 check("r0_regwr", bus_b.dec_ctrl[1], 1'b0);
        step();

        for (int c = 0; c < 800; c++) begin
            nRST = !($urandom_range(99) == 0 || c % 80 == 79);
            iv = ($urandom_range(9) != 0);
            instr = rand_instr();
            for (int k = 0; k < SA; k++) begin
                en_a[k] = ($urandom_range(9) < 8);
                fl_a[k] = ($urandom_range(19) == 0);
            end
            for (int k = 0; k < SB; k++) begin
                en_b[k] = ($urandom_range(9) < 8);
                fl_b[k] = ($urandom_range(19) == 0);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
